// File: rtl/micro_next_addr_ctrl.sv
// micro_next_addr_ctrl: microinstruction consumer and next-address controller.
//
// Splits the MIR word into registered datapath controls, latches the ALU flags,
// runs the memory-wait handshake with a timeout trap, and returns the
// next-address controls to the control-store sequencer.
//
// Ports:
//   clk        rising-edge clock (sequencer samples addr/addr_sel on falling edge)
//   rst_n      asynchronous active-low reset
//   mir        microinstruction {NEXT, JMPC, JAMN, JAMZ, ALU, C, MEM{WR,RD,FETCH}, B}
//   alu_z/n    ALU zero/negative of the executing microinstruction
//   mem_ready  memory completes the outstanding request this cycle
//   addr       next control-store address
//   addr_sel   1 = sequencer takes next address from MBRU (JMPC dispatch)
//   JUMP       fixed-target conditional jump request (legacy build only)
//   Z_flag     latched zero flag
//   alu_ctrl, c_en, b_sel          registered datapath controls
//   mem_rd, mem_wr, mem_fetch      memory request strobes
//   mem_err    sticky memory-timeout flag, cleared only by reset
//
// Build option: define LEGACY_JUMP_EN to route JAMZ through JUMP/Z_flag instead
// of OR-ing it into addr bit 7.

module micro_next_addr_ctrl #(
  parameter int unsigned          MIRWIDTH    = 31,
  parameter int unsigned          BYTEWIDTH   = 8,
  parameter int unsigned          MEM_TIMEOUT = 15,
  parameter logic [BYTEWIDTH-1:0] TRAP_ADDR   = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MIRWIDTH-1:0]  mir,
  input  logic                 alu_z,
  input  logic                 alu_n,
  input  logic                 mem_ready,
  output logic [BYTEWIDTH-1:0] addr,
  output logic                 addr_sel,
  output logic                 JUMP,
  output logic                 Z_flag,
  output logic [5:0]           alu_ctrl,
  output logic [6:0]           c_en,
  output logic [3:0]           b_sel,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 mem_fetch,
  output logic                 mem_err
);

  localparam int unsigned      CntW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {StRun, StWait, StTrap} state_e;

  state_e r_state, w_state_d;

  logic [BYTEWIDTH-1:0] r_addr, w_addr_d;
  logic                 r_addr_sel, w_addr_sel_d;
  logic                 r_jump, w_jump_d;
  logic                 r_z_flag, w_z_flag_d;
  logic                 r_n_flag, w_n_flag_d;
  logic [5:0]           r_alu_ctrl, w_alu_ctrl_d;
  logic [6:0]           r_c_en, w_c_en_d;
  logic [3:0]           r_b_sel, w_b_sel_d;
  logic                 r_mem_rd, w_mem_rd_d;
  logic                 r_mem_wr, w_mem_wr_d;
  logic                 r_mem_fetch, w_mem_fetch_d;
  logic                 r_mem_err, w_mem_err_d;
  logic [CntW-1:0]      r_wait_cnt, w_wait_cnt_d;

  // MIR field decode
  logic [7:0] w_next;
  logic       w_jmpc, w_jamn, w_jamz;
  logic [5:0] w_alu;
  logic [6:0] w_c;
  logic [2:0] w_mem;
  logic [3:0] w_b;
  logic       w_mem_req;
  logic       w_stall;
  logic [CntW-1:0] w_cnt_inc;
  logic [7:0] w_addr_run;
  logic       w_jump_run;

  assign w_next    = mir[30:23];
  assign w_jmpc    = mir[22];
  assign w_jamn    = mir[21];
  assign w_jamz    = mir[20];
  assign w_alu     = mir[19:14];
  assign w_c       = mir[13:7];
  assign w_mem     = mir[6:4];
  assign w_b       = mir[3:0];
  assign w_mem_req = |w_mem;
  assign w_stall   = w_mem_req & ~mem_ready;
  assign w_cnt_inc = r_wait_cnt + 1'b1;

  // Branch conditions use this cycle's ALU flags, not the latched ones.
`ifdef LEGACY_JUMP_EN
  assign w_addr_run = {w_next[7] | (w_jamn & alu_n), w_next[6:0]};
  assign w_jump_run = w_jamz;
`else
  assign w_addr_run = {w_next[7] | (w_jamz & alu_z) | (w_jamn & alu_n), w_next[6:0]};
  assign w_jump_run = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StRun;
      r_addr      <= '0;
      r_addr_sel  <= 1'b0;
      r_jump      <= 1'b0;
      r_z_flag    <= 1'b0;
      r_n_flag    <= 1'b0;
      r_alu_ctrl  <= '0;
      r_c_en      <= '0;
      r_b_sel     <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_fetch <= 1'b0;
      r_mem_err   <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_addr      <= w_addr_d;
      r_addr_sel  <= w_addr_sel_d;
      r_jump      <= w_jump_d;
      r_z_flag    <= w_z_flag_d;
      r_n_flag    <= w_n_flag_d;
      r_alu_ctrl  <= w_alu_ctrl_d;
      r_c_en      <= w_c_en_d;
      r_b_sel     <= w_b_sel_d;
      r_mem_rd    <= w_mem_rd_d;
      r_mem_wr    <= w_mem_wr_d;
      r_mem_fetch <= w_mem_fetch_d;
      r_mem_err   <= w_mem_err_d;
      r_wait_cnt  <= w_wait_cnt_d;
    end
  end

  // Next state; mem_ready takes priority over the timeout.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StRun:  if (w_stall) w_state_d = StWait;
      StWait: begin
        if (mem_ready)                     w_state_d = StRun;
        else if (w_cnt_inc == TimeoutCnt)  w_state_d = StTrap;
      end
      StTrap: w_state_d = StRun;
      default: w_state_d = StRun;
    endcase
  end

  // Next register values
  always_comb begin
    w_addr_d      = r_addr;
    w_addr_sel_d  = r_addr_sel;
    w_jump_d      = r_jump;
    w_z_flag_d    = r_z_flag;
    w_n_flag_d    = r_n_flag;
    w_alu_ctrl_d  = r_alu_ctrl;
    w_c_en_d      = r_c_en;
    w_b_sel_d     = r_b_sel;
    w_mem_rd_d    = r_mem_rd;
    w_mem_wr_d    = r_mem_wr;
    w_mem_fetch_d = r_mem_fetch;
    w_mem_err_d   = r_mem_err;
    w_wait_cnt_d  = r_wait_cnt;
    unique case (r_state)
      StRun: begin
        w_addr_d      = BYTEWIDTH'(w_addr_run);
        w_addr_sel_d  = w_jmpc;
        w_jump_d      = w_jump_run;
        w_z_flag_d    = alu_z;
        w_n_flag_d    = alu_n;
        w_alu_ctrl_d  = w_alu;
        w_b_sel_d     = w_b;
        w_mem_wr_d    = w_mem[2];
        w_mem_rd_d    = w_mem[1];
        w_mem_fetch_d = w_mem[0];
        // A stalled access holds off the C-bus write until memory completes;
        // the RUN cycle already counts as the first wait cycle.
        w_c_en_d      = w_stall ? 7'b0 : w_c;
        w_wait_cnt_d  = w_stall ? CntW'(1) : '0;
      end
      StWait: begin
        if (mem_ready) begin
          w_mem_wr_d    = 1'b0;
          w_mem_rd_d    = 1'b0;
          w_mem_fetch_d = 1'b0;
          w_c_en_d      = w_c;
          w_wait_cnt_d  = '0;
        end else begin
          w_c_en_d      = '0;
          w_wait_cnt_d  = w_cnt_inc;
        end
      end
      StTrap: begin
        w_addr_d      = TRAP_ADDR;
        w_addr_sel_d  = 1'b0;
        w_jump_d      = 1'b0;
        w_mem_wr_d    = 1'b0;
        w_mem_rd_d    = 1'b0;
        w_mem_fetch_d = 1'b0;
        w_c_en_d      = '0;
        w_mem_err_d   = 1'b1;
        w_wait_cnt_d  = '0;
      end
      default: ;
    endcase
  end

  // N flag is latched for completeness but has no consumer on this block.
  logic w_unused;
  assign w_unused = r_n_flag;

  assign addr      = r_addr;
  assign addr_sel  = r_addr_sel;
  assign JUMP      = r_jump;
  assign Z_flag    = r_z_flag;
  assign alu_ctrl  = r_alu_ctrl;
  assign c_en      = r_c_en;
  assign b_sel     = r_b_sel;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_fetch = r_mem_fetch;
  assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_micro_next_addr_ctrl.sv
module tb_micro_next_addr_ctrl;

  localparam int MemTimeout = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [30:0] mir;
  logic        alu_z, alu_n, mem_ready;
  logic [7:0]  addr;
  logic        addr_sel, JUMP, Z_flag;
  logic [5:0]  alu_ctrl;
  logic [6:0]  c_en;
  logic [3:0]  b_sel;
  logic        mem_rd, mem_wr, mem_fetch, mem_err;

  micro_next_addr_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mir       (mir),
    .alu_z     (alu_z),
    .alu_n     (alu_n),
    .mem_ready (mem_ready),
    .addr      (addr),
    .addr_sel  (addr_sel),
    .JUMP      (JUMP),
    .Z_flag    (Z_flag),
    .alu_ctrl  (alu_ctrl),
    .c_en      (c_en),
    .b_sel     (b_sel),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_fetch (mem_fetch),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs
  logic [7:0] e_addr;
  logic       e_sel, e_jump, e_z;
  logic [5:0] e_alu;
  logic [6:0] e_c_en;
  logic [3:0] e_b;
  logic       e_rd, e_wr, e_fetch, e_err;

  // Transaction-level view of the memory handshake
  bit waiting;
  int waited;
  bit trap_pending;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_addr = 8'h00; e_sel = 0; e_jump = 0; e_z = 0; e_alu = 0; e_c_en = 0; e_b = 0;
    e_rd = 0; e_wr = 0; e_fetch = 0; e_err = 0;
    waiting = 0; waited = 0; trap_pending = 0;
  endtask

  // Predict outputs after the next rising edge from the inputs presented now.
  task automatic model_step(input logic [30:0] m, input logic z, input logic n, input logic rdy);
    bit taken;
    bit jamz, jamn, legacy;
    jamn = m[21];
    jamz = m[20];
`ifdef LEGACY_JUMP_EN
    legacy = 1;
`else
    legacy = 0;
`endif
    if (trap_pending) begin
      e_addr = 8'hFF; e_sel = 0; e_jump = 0; e_rd = 0; e_wr = 0; e_fetch = 0;
      e_c_en = 0; e_err = 1; trap_pending = 0;
    end else if (waiting) begin
      if (rdy) begin
        e_rd = 0; e_wr = 0; e_fetch = 0; e_c_en = m[13:7]; waiting = 0;
      end else begin
        waited++;
        e_c_en = 0;
        if (waited >= MemTimeout) begin
          waiting = 0;
          trap_pending = 1;
        end
      end
    end else begin
      taken  = legacy ? (jamn && n) : ((jamz && z) || (jamn && n));
      e_addr = m[30:23] | (taken ? 8'h80 : 8'h00);
      e_sel  = m[22];
      e_jump = legacy ? jamz : 1'b0;
      e_z    = z;
      e_alu  = m[19:14];
      e_b    = m[3:0];
      e_wr   = m[6];
      e_rd   = m[5];
      e_fetch = m[4];
      if (m[6:4] != 3'b000 && !rdy) begin
        waiting = 1;
        waited  = 1;
        e_c_en  = 0;
      end else begin
        e_c_en = m[13:7];
      end
    end
  endtask

  task automatic compare_all();
    check_eq("addr", 32'(addr), 32'(e_addr));
    check_eq("addr_sel", 32'(addr_sel), 32'(e_sel));
    check_eq("JUMP", 32'(JUMP), 32'(e_jump));
    check_eq("Z_flag", 32'(Z_flag), 32'(e_z));
    check_eq("alu_ctrl", 32'(alu_ctrl), 32'(e_alu));
    check_eq("c_en", 32'(c_en), 32'(e_c_en));
    check_eq("b_sel", 32'(b_sel), 32'(e_b));
    check_eq("mem_rd", 32'(mem_rd), 32'(e_rd));
    check_eq("mem_wr", 32'(mem_wr), 32'(e_wr));
    check_eq("mem_fetch", 32'(mem_fetch), 32'(e_fetch));
    check_eq("mem_err", 32'(mem_err), 32'(e_err));
  endtask

  function automatic logic [30:0] mk_mir(input logic [7:0] nxt, input logic jmpc, input logic jamn,
                                         input logic jamz, input logic [5:0] alu,
                                         input logic [6:0] c, input logic [2:0] mem,
                                         input logic [3:0] b);
    return {nxt, jmpc, jamn, jamz, alu, c, mem, b};
  endfunction

  // Called at a falling edge: drive, predict, advance one cycle, compare.
  task automatic cycle(input logic [30:0] m, input logic z, input logic n, input logic rdy);
    mir = m; alu_z = z; alu_n = n; mem_ready = rdy;
    model_step(m, z, n, rdy);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset pulse between rising edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1;
    rst_n = 1'b1;
  endtask

  logic [30:0] m_rd;

  initial begin
    rst_n = 1'b0; mir = '0; alu_z = 0; alu_n = 0; mem_ready = 0;
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Conditional branch on Z
    cycle(mk_mir(8'h12, 0, 0, 1, 6'h05, 7'h01, 3'b000, 4'h3), 1, 0, 0);
`ifdef LEGACY_JUMP_EN
    check_eq("legacy_addr", 32'(addr), 32'h12);
    check_eq("legacy_jump", 32'(JUMP), 32'h1);
`else
    check_eq("jamz_taken_addr", 32'(addr), 32'h92);
`endif
    check_eq("jamz_zflag", 32'(Z_flag), 32'h1);
    cycle(mk_mir(8'h12, 0, 0, 1, 6'h05, 7'h01, 3'b000, 4'h3), 0, 0, 0);
    check_eq("jamz_not_taken_addr", 32'(addr), 32'h12);
    check_eq("jamz_zflag_clr", 32'(Z_flag), 32'h0);

    // JMPC dispatch
    cycle(mk_mir(8'h00, 1, 0, 0, 6'h00, 7'h00, 3'b000, 4'h0), 0, 0, 0);
    check_eq("jmpc_sel", 32'(addr_sel), 32'h1);
    check_eq("jmpc_addr", 32'(addr), 32'h0);

    // Read stalled for three cycles
    m_rd = mk_mir(8'h20, 0, 0, 0, 6'h11, 7'b0000100, 3'b010, 4'h2);
    for (int i = 0; i < 3; i++) begin
      cycle(m_rd, 0, 0, 0);
      check_eq("wait_c_en", 32'(c_en), 32'h0);
      check_eq("wait_mem_rd", 32'(mem_rd), 32'h1);
    end
    cycle(m_rd, 0, 0, 1);
    check_eq("ready_c_en", 32'(c_en), 32'h4);
    check_eq("ready_mem_rd", 32'(mem_rd), 32'h0);

    // Timeout into the trap address
    for (int i = 0; i < MemTimeout + 1; i++) cycle(m_rd, 0, 0, 0);
    check_eq("trap_addr", 32'(addr), 32'hFF);
    check_eq("trap_err", 32'(mem_err), 32'h1);
    cycle(mk_mir(8'h33, 0, 0, 0, 6'h01, 7'h02, 3'b001, 4'h1), 0, 0, 1);
    check_eq("err_sticky", 32'(mem_err), 32'h1);

    // Reset in the middle of a wait
    cycle(m_rd, 0, 0, 0);
    cycle(m_rd, 0, 0, 0);
    pulse_reset();
    check_eq("rst_mem_rd", 32'(mem_rd), 32'h0);
    cycle(mk_mir(8'h45, 0, 0, 0, 6'h02, 7'h08, 3'b000, 4'h5), 0, 0, 0);
    check_eq("post_rst_c_en", 32'(c_en), 32'h8);

    // Randomised traffic with varying memory latency
    for (int ph = 0; ph < 24; ph++) begin
      int pct;
      case (ph % 4)
        0: pct = 90;
        1: pct = 50;
        2: pct = 15;
        default: pct = 0;
      endcase
      for (int i = 0; i < 100; i++) begin
        logic [30:0] m;
        m = 31'($urandom);
        if ($urandom_range(0, 3) == 0) m[6:4] = 3'b000;
        if ($urandom_range(0, 399) == 0) begin
          pulse_reset();
        end
        cycle(m, 1'($urandom), 1'($urandom), ($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
